// File: rtl/hamming_chunk_feeder_if.sv
// Chunk handshake between the Hamming chunk feeder (master) and the
// XOR/popcount accumulator (slave), including the accumulator's running sum.
interface hamming_chunk_feeder_if #(
  parameter int W  = 1000,
  parameter int RW = 14
);
  logic          chunk_valid;
  logic          chunk_ready;
  logic [W-1:0]  x_chunk;
  logic [W-1:0]  y_chunk;
  logic          chunk_first;
  logic          chunk_last;
  logic [RW-1:0] result_in;

  modport master (
    output chunk_valid,
    output x_chunk,
    output y_chunk,
    output chunk_first,
    output chunk_last,
    input  chunk_ready,
    input  result_in
  );

  modport slave (
    input  chunk_valid,
    input  x_chunk,
    input  y_chunk,
    input  chunk_first,
    input  chunk_last,
    output chunk_ready,
    output result_in
  );
endinterface

// File: rtl/hamming_chunk_feeder.sv
// Latches two N-bit operands and streams them as CC chunks of W bits into the
// XOR/popcount accumulator, capturing its running sum on the final transfer.
module hamming_chunk_feeder #(
  parameter  int N  = 16000,
  parameter  int CC = 16,
  localparam int W  = N / CC,
  localparam int RW = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N-1:0]           x_in,
  input  logic [N-1:0]           y_in,
  output logic                   busy,
  hamming_chunk_feeder_if.master ch,
  output logic [RW-1:0]          result,
  output logic                   done
);

  localparam int IW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CC - 1);

  generate
    if ((N % CC) != 0) begin : g_bad_split
      $error("hamming_chunk_feeder: N must be divisible by CC");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  xs_q, xs_d;
  logic [N-1:0]  ys_q, ys_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] result_q, result_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // In STREAM, chunk_valid is implied, so a transfer is just chunk_ready.
  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          xs_d    = x_in;
          ys_d    = y_in;
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (ch.chunk_ready) begin
          if (idx_q == LAST_IDX) begin
            result_d = ch.result_in;
            state_d  = S_DONE;
          end else begin
            xs_d  = xs_q >> W;
            ys_d  = ys_q >> W;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Every output is decoded straight from registers: no ready-to-chunk path.
  assign ch.chunk_valid = (state_q == S_STREAM);
  assign ch.x_chunk     = xs_q[W-1:0];
  assign ch.y_chunk     = ys_q[W-1:0];
  assign ch.chunk_first = (state_q == S_STREAM) && (idx_q == '0);
  assign ch.chunk_last  = (state_q == S_STREAM) && (idx_q == LAST_IDX);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign result         = result_q;

endmodule

// File: tb/tb_hamming_chunk_feeder.sv
// Scoreboard bench for hamming_chunk_feeder: N=16/CC=4 main instance with a
// behavioural accumulator, plus an N=8/CC=1 instance for the single-chunk case.
module tb_hamming_chunk_feeder;

  localparam int N  = 16;
  localparam int CC = 4;
  localparam int W  = N / CC;
  localparam int RW = $clog2(N + 1);

  localparam int N1  = 8;
  localparam int RW1 = $clog2(N1 + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  x_in, y_in;
  logic          busy, done;
  logic [RW-1:0] result;

  logic           start1;
  logic [N1-1:0]  x1_in, y1_in;
  logic           busy1, done1;
  logic [RW1-1:0] result1;

  hamming_chunk_feeder_if #(.W(W),  .RW(RW))  cif ();
  hamming_chunk_feeder_if #(.W(N1), .RW(RW1)) cif1 ();

  hamming_chunk_feeder #(.N(N), .CC(CC)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_in   (x_in),
    .y_in   (y_in),
    .busy   (busy),
    .ch     (cif),
    .result (result),
    .done   (done)
  );

  hamming_chunk_feeder #(.N(N1), .CC(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .x_in   (x1_in),
    .y_in   (y1_in),
    .busy   (busy1),
    .ch     (cif1),
    .result (result1),
    .done   (done1)
  );

  // Accumulator models: running popcount of x^y, restarting on the first chunk
  logic [RW-1:0] acc;
  assign cif.result_in = (cif.chunk_first ? RW'(0) : acc)
                       + RW'($countones(cif.x_chunk ^ cif.y_chunk));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= '0;
    else if (cif.chunk_valid && cif.chunk_ready) acc <= cif.result_in;
  end
  assign cif1.result_in = RW1'($countones(cif1.x_chunk ^ cif1.y_chunk));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: {x_chunk, y_chunk, first, last} per transfer, distance per op
  logic [2*W+1:0] exp_chunk_q[$];
  logic [RW-1:0]  exp_res_q[$];
  int             op_num = 0;

  task automatic push_expect(input logic [N-1:0] x, input logic [N-1:0] y);
    for (int k = 0; k < CC; k++)
      exp_chunk_q.push_back({x[k*W +: W], y[k*W +: W], (k == 0), (k == CC - 1)});
    exp_res_q.push_back(RW'($countones(x ^ y)));
    $display("op %0d: x=%h y=%h expected distance=%0d", op_num, x, y, $countones(x ^ y));
    op_num++;
  endtask

  // Ready generator: 0 = held high, 1 = random, 2 = follow man_ready
  int   rdy_mode  = 0;
  logic man_ready = 1'b1;
  initial begin
    cif.chunk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       cif.chunk_ready = 1'b1;
        1:       cif.chunk_ready = 1'($urandom_range(0, 1));
        default: cif.chunk_ready = man_ready;
      endcase
    end
  end

  // Monitor
  int   cur_len  = 0;
  int   last_len = 0;
  logic prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur_len   = 0;
        prev_done = 1'b0;
      end else begin
        if (cif.chunk_valid) cur_len++;
        else if (cur_len != 0) begin
          last_len = cur_len;
          cur_len  = 0;
        end
        if (cif.chunk_valid && cif.chunk_ready) begin
          if (exp_chunk_q.size() == 0) chk("chunk_unexpected", 32'd1, 32'd0);
          else chk("chunk", 32'({cif.x_chunk, cif.y_chunk, cif.chunk_first, cif.chunk_last}),
                   32'(exp_chunk_q.pop_front()));
        end
        if (done) begin
          chk("done_width", 32'(prev_done), 32'd0);
          if (exp_res_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
          else chk("result", 32'(result), 32'(exp_res_q.pop_front()));
        end
        prev_done = done;
      end
    end
  end

  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit push);
    @(posedge clk);
    #1;
    start = 1'b1;
    x_in  = x;
    y_in  = y;
    if (push) push_expect(x, y);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rx, ry;
    rst = 1'b0; start = 1'b0; x_in = '0; y_in = '0;
    start1 = 1'b0; x1_in = '0; y1_in = '0;
    cif1.chunk_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_valid",  32'(cif.chunk_valid), 32'd0);
    chk("rst_first",  32'(cif.chunk_first), 32'd0);
    chk("rst_last",   32'(cif.chunk_last), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_chunks", 32'({cif.x_chunk, cif.y_chunk}), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Full-distance and zero-distance streams with ready held high
    rdy_mode = 0;
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_done();
    start_op(16'hA5C3, 16'hA5C3, 1'b1);
    wait_done();

    // Start during DONE is ignored
    start = 1'b1; x_in = 16'h1111; y_in = 16'h2222;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    chk("result_held_idle", 32'(result), 32'd0);

    // Stall on STREAM cycles 2 and 3
    rdy_mode = 2; man_ready = 1'b1;
    start_op(16'h1234, 16'h4321, 1'b1);
    @(posedge clk); #1; man_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; man_ready = 1'b1;
    wait_done();
    @(negedge clk);
    chk("stall_stream_cycles", 32'(last_len), 32'd6);

    // Start during STREAM is ignored; previous result held meanwhile
    rdy_mode = 0;
    start_op(16'h00FF, 16'h0F0F, 1'b1);
    start_op(16'hDEAD, 16'hBEEF, 1'b0);
    chk("result_hold_stream", 32'(result), 32'd6);
    wait_done();

    // Reset after two transfers
    start_op(16'hCAFE, 16'h1357, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid",  32'(cif.chunk_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_busy",   32'(busy), 32'd0);
    exp_chunk_q.delete();
    exp_res_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    start_op(16'h8001, 16'h0001, 1'b1);
    @(negedge clk);
    chk("after_rst_first", 32'(cif.chunk_first), 32'd1);
    chk("after_rst_chunk0", 32'(cif.x_chunk), 32'h1);
    wait_done();

    // Randomized operands with random ready
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      rx = 16'($urandom);
      ry = (i % 5 == 0) ? rx ^ 16'(1 << (i % 16)) : 16'($urandom);
      start_op(rx, ry, 1'b1);
      wait_done();
    end
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    chk("scoreboard_chunks_drained", 32'(exp_chunk_q.size()), 32'd0);
    chk("scoreboard_results_drained", 32'(exp_res_q.size()), 32'd0);

    // Single-chunk instance
    @(posedge clk); #1;
    start1 = 1'b1; x1_in = 8'h0F; y1_in = 8'hF0;
    $display("op cc1: x=%h y=%h expected distance=8", x1_in, y1_in);
    @(posedge clk); #1; start1 = 1'b0;
    @(negedge clk);
    chk("cc1_valid", 32'(cif1.chunk_valid), 32'd1);
    chk("cc1_first_last", 32'({cif1.chunk_first, cif1.chunk_last}), 32'h3);
    chk("cc1_chunks", 32'({cif1.x_chunk, cif1.y_chunk}), 32'h0FF0);
    @(negedge clk);
    chk("cc1_done", 32'(done1), 32'd1);
    chk("cc1_result", 32'(result1), 32'd8);
    @(negedge clk);
    chk("cc1_done_pulse", 32'({done1, busy1}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
